// File: rtl/decoder_reg_file.sv
// rtl/decoder_reg_file.sv - instruction field decoder plus 2-read/1-write register file
//
// Purpose:
//   Splits an instruction word into its opcode/register/shift/function fields
//   with no clocking, and holds a 2**RA_WIDTH x D_WIDTH register file with two
//   asynchronous read ports and one synchronous write port. Register 0 is
//   hard-wired to zero. While dis is high the file is frozen, and the rising
//   edge of dis triggers a one-time simulation dump of every register.
//
// Ports:
//   Clk, Rst                    clock, synchronous active-high reset
//   IR                          instruction word
//   op, rs, rt, rd, sh, fn      decoded fields of IR
//   R1_Addr, R1_en, R1_Data     read port 1
//   R2_Addr, R2_en, R2_Data     read port 2
//   W_Addr, W_en, W_Data        write port
//   dis                         freeze / dump request

module decoder_reg_file #(
    parameter int D_WIDTH  = 32,
    parameter int RA_WIDTH = 5
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [D_WIDTH-1:0]  IR,
    output logic [5:0]          op,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          sh,
    output logic [5:0]          fn,
    input  logic [RA_WIDTH-1:0] R1_Addr,
    input  logic [RA_WIDTH-1:0] R2_Addr,
    input  logic [RA_WIDTH-1:0] W_Addr,
    input  logic                R1_en,
    input  logic                R2_en,
    input  logic                W_en,
    output logic [D_WIDTH-1:0]  R1_Data,
    output logic [D_WIDTH-1:0]  R2_Data,
    input  logic [D_WIDTH-1:0]  W_Data,
    input  logic                dis
);

    localparam int N_REGS = 2 ** RA_WIDTH;

    // Decoder: fixed slices, no clock, no reset. {rd,sh,fn} == IR[15:0].
    assign op = IR[31:26];
    assign rs = IR[25:21];
    assign rt = IR[20:16];
    assign rd = IR[15:11];
    assign sh = IR[10:6];
    assign fn = IR[5:0];

    // Register storage. Entry 0 is cleared by reset and never written; the
    // read muxes also force address 0 to zero so it cannot leak anything.
    logic [D_WIDTH-1:0] regs [N_REGS];

    logic wr_fire;
    assign wr_fire = W_en && !dis && (W_Addr != '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[W_Addr] <= W_Data;
        end
    end

    // Asynchronous reads with no write bypass: a same-cycle write is only
    // visible after the edge that commits it.
    assign R1_Data = (R1_en && (R1_Addr != '0)) ? regs[R1_Addr] : '0;
    assign R2_Data = (R2_en && (R2_Addr != '0)) ? regs[R2_Addr] : '0;

    // Dis rise detector. dis_armed is high only when dis was sampled low at
    // the previous non-reset edge, so reset leaves it at 0 and a dis level
    // already high coming out of reset never produces a dump.
    logic dis_armed;
    logic dump_fire;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dis_armed <= 1'b0;
        end else begin
            dis_armed <= !dis;
        end
    end

    assign dump_fire = !Rst && dis && dis_armed;

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (dump_fire) begin
            for (int i = 0; i < N_REGS; i++) begin
                $display("R%0d = 0x%h", i, regs[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_decoder_reg_file.sv
// tb/tb_decoder_reg_file.sv - scoreboard bench for decoder_reg_file
module tb_decoder_reg_file;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] IR = '0;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [4:0]  R1_Addr = '0, R2_Addr = '0, W_Addr = '0;
    logic        R1_en = 1'b0, R2_en = 1'b0, W_en = 1'b0;
    logic [31:0] R1_Data, R2_Data;
    logic [31:0] W_Data = '0;
    logic        dis = 1'b0;

    decoder_reg_file #(.D_WIDTH(32), .RA_WIDTH(5)) dut (
        .Clk(Clk), .Rst(Rst), .IR(IR),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .sh(sh), .fn(fn),
        .R1_Addr(R1_Addr), .R2_Addr(R2_Addr), .W_Addr(W_Addr),
        .R1_en(R1_en), .R2_en(R2_en), .W_en(W_en),
        .R1_Data(R1_Data), .R2_Data(R2_Data), .W_Data(W_Data),
        .dis(dis)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          vectors = 0;
    int          errors = 0;
    int          dump_count = 0;

    // Reference register file: reset clears, writes need W_en, !dis, addr != 0.
    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (W_en && !dis && W_Addr != 5'd0) begin
            model[W_Addr] <= W_Data;
        end
    end

    always @(posedge Clk) begin
        if (dut.dump_fire) dump_count <= dump_count + 1;
    end

    task automatic drive_reads(input logic [4:0] a1, input logic e1,
                               input logic [4:0] a2, input logic e2, input string tag);
        exp_t e;
        R1_Addr = a1; R1_en = e1; R2_Addr = a2; R2_en = e2;
        e.name = $sformatf("%s_r1[%0d]", tag, a1); e.port = 1'b0;
        e.val = e1 ? model[a1] : 32'd0;
        sb.push_back(e);
        e.name = $sformatf("%s_r2[%0d]", tag, a2); e.port = 1'b1;
        e.val = e2 ? model[a2] : 32'd0;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge Clk);
        W_en = 1'b1; W_Addr = a; W_Data = d;
        @(negedge Clk);
        W_en = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        logic [31:0] obs;
        repeat (2) @(negedge Clk);
        IR = 32'hFC00_0000;
        #1;
        vectors++;
        if (op !== 6'h3F) begin
            errors++; $display("FAIL reset_decode_op: got %h expected %h", op, 6'h3F);
        end
        @(negedge Clk);
        Rst = 1'b0;
        drive_reads(5'd1, 1'b1, 5'd31, 1'b1, "reset");
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            obs = e.port ? R2_Data : R1_Data;
            vectors++;
            if (obs !== e.val || e.val !== 32'd0) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs, 32'd0);
            end
        end
    endtask

    task automatic test_decode;
        logic [31:0] v;
        IR = 32'h2001_000A;
        #1;
        vectors++;
        if ({op, rs, rt, rd, sh, fn} !== {6'd8, 5'd0, 5'd1, 5'd0, 5'd0, 6'd10}) begin
            errors++;
            $display("FAIL decode_fields: got op=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%0d expected 8 0 1 0 0 10",
                     op, rs, rt, rd, sh, fn);
        end
        vectors++;
        if ({rd, sh, fn} !== 16'h000A) begin
            errors++; $display("FAIL decode_imm: got %h expected %h", {rd, sh, fn}, 16'h000A);
        end
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            IR = v;
            #1;
            vectors++;
            if ({op, rs, rt, {rd, sh, fn}} !== {v[31:26], v[25:21], v[20:16], v[15:0]}) begin
                errors++;
                $display("FAIL decode_rand: IR=%h got %h_%h_%h_%h", v, op, rs, rt, {rd, sh, fn});
            end
        end
    endtask

    task automatic test_write_read;
        exp_t e;
        logic [31:0] obs;
        do_write(5'd1, 32'h0000_000A);
        drive_reads(5'd1, 1'b1, 5'd1, 1'b0, "wr");
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            obs = e.port ? R2_Data : R1_Data;
            vectors++;
            if (obs !== e.val) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        vectors++;
        if (R1_Data !== 32'h0000_000A) begin
            errors++; $display("FAIL wr_const: got %h expected %h", R1_Data, 32'h0000_000A);
        end
        R1_en = 1'b0;
        #1;
        vectors++;
        if (R1_Data !== 32'd0) begin
            errors++; $display("FAIL wr_disabled: got %h expected %h", R1_Data, 32'd0);
        end
    endtask

    task automatic test_reg0;
        exp_t e;
        logic [31:0] obs;
        do_write(5'd0, 32'hFFFF_FFFF);
        drive_reads(5'd0, 1'b1, 5'd0, 1'b1, "reg0");
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            obs = e.port ? R2_Data : R1_Data;
            vectors++;
            if (obs !== e.val || obs !== 32'd0) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs, 32'd0);
            end
        end
    endtask

    task automatic test_same_addr_rdw;
        exp_t e;
        logic [31:0] obs;
        do_write(5'd5, 32'h1234_5678);
        drive_reads(5'd5, 1'b1, 5'd5, 1'b1, "dual");
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            obs = e.port ? R2_Data : R1_Data;
            vectors++;
            if (obs !== e.val || obs !== 32'h1234_5678) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs, 32'h1234_5678);
            end
        end
        @(negedge Clk);
        W_en = 1'b1; W_Addr = 5'd5; W_Data = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (R1_Data !== 32'h1234_5678 || R2_Data !== 32'h1234_5678) begin
            errors++; $display("FAIL rdw_before: got %h/%h expected %h", R1_Data, R2_Data, 32'h1234_5678);
        end
        @(posedge Clk);
        #1;
        W_en = 1'b0;
        vectors++;
        if (R1_Data !== 32'hDEAD_BEEF || R2_Data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rdw_after: got %h/%h expected %h", R1_Data, R2_Data, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_freeze;
        exp_t e;
        logic [31:0] obs;
        do_write(5'd3, 32'h0000_0033);
        @(negedge Clk);
        dump_count = 0;
        dis = 1'b1; W_en = 1'b1; W_Addr = 5'd3; W_Data = 32'h0000_0055;
        repeat (3) @(negedge Clk);
        W_en = 1'b0;
        drive_reads(5'd3, 1'b1, 5'd5, 1'b1, "frz");
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            obs = e.port ? R2_Data : R1_Data;
            vectors++;
            if (obs !== e.val) begin
                errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        vectors++;
        if (R1_Data !== 32'h0000_0033) begin
            errors++; $display("FAIL frz_reg3: got %h expected %h", R1_Data, 32'h0000_0033);
        end
        vectors++;
        if (dump_count !== 1) begin
            errors++; $display("FAIL frz_dump_count: got %0d expected 1", dump_count);
        end
        @(negedge Clk);
        dis = 1'b0;
        do_write(5'd3, 32'h0000_0055);
        R1_Addr = 5'd3; R1_en = 1'b1;
        #1;
        vectors++;
        if (R1_Data !== 32'h0000_0055) begin
            errors++; $display("FAIL unfrz_reg3: got %h expected %h", R1_Data, 32'h0000_0055);
        end
    endtask

    task automatic test_reset_mid;
        do_write(5'd7, 32'h0000_0077);
        R1_Addr = 5'd7; R1_en = 1'b1;
        #1;
        vectors++;
        if (R1_Data !== 32'h0000_0077) begin
            errors++; $display("FAIL rstmid_pre: got %h expected %h", R1_Data, 32'h0000_0077);
        end
        @(negedge Clk);
        Rst = 1'b1; W_en = 1'b1; W_Addr = 5'd7; W_Data = 32'h0000_00AA;
        IR = 32'h2001_000A;
        #1;
        vectors++;
        if (op !== 6'd8 || fn !== 6'd10) begin
            errors++; $display("FAIL rst_decode: got op=%0d fn=%0d expected 8 10", op, fn);
        end
        @(negedge Clk);
        Rst = 1'b0; W_en = 1'b0;
        #1;
        vectors++;
        if (R1_Data !== 32'd0) begin
            errors++; $display("FAIL rstmid_reg7: got %h expected %h", R1_Data, 32'd0);
        end
        // dis already high when reset releases must not dump.
        dump_count = 0;
        @(negedge Clk);
        Rst = 1'b1; dis = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        vectors++;
        if (dump_count !== 0) begin
            errors++; $display("FAIL rst_dis_nodump: got %0d expected 0", dump_count);
        end
        dis = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [31:0] obs;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            W_en = 1'b1;
            W_Addr = 5'($urandom_range(0, 31));
            W_Data = $urandom;
        end
        @(negedge Clk);
        W_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            drive_reads(5'(a), 1'b1, 5'(31 - a), 1'b1, "b2b");
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                obs = e.port ? R2_Data : R1_Data;
                vectors++;
                if (obs !== e.val) begin
                    errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_write_read();
        test_reg0();
        test_same_addr_rdw();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
